// File: rtl/gate2_vector_checker_if.sv
// Bundle between the vector checker and the 2-input gate it exercises,
// plus the start/status signals seen by whoever launches the sweep.
interface gate2_vector_checker_if #(
  parameter int ERR_W = 3
);
  logic             start;
  logic             dut_x;
  logic             dut_y;
  logic             dut_z;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  // Checker side: drives the gate inputs and reports results.
  modport master (
    input  start, dut_z,
    output dut_x, dut_y, busy, done, pass, err_count, fail_vec
  );

  // Environment side: launches sweeps, hosts the gate, reads results.
  modport slave (
    output start, dut_z,
    input  dut_x, dut_y, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate2_vector_checker.sv
// Hardware self-test for a 2-input combinational gate: steps x/y through
// 00, 01, 10, 11, lets each vector settle, samples z once at the end of the
// window and compares it to the EXPECT_MASK truth table.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | after reset, waiting for start; results cleared
//   SETTLE | current vector driven, settle down-counter running
//   CHECK  | single cycle: dut_z sampled and compared for vector idx
//   DONE   | sweep finished; results held until next start or reset
module gate2_vector_checker #(
  parameter logic [3:0] EXPECT_MASK   = 4'b1000,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ERR_W         = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  gate2_vector_checker_if.master  bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Counter reloads to SETTLE_CYCLES-1 so the vector spends SETTLE_CYCLES
  // cycles in SETTLE followed by the one CHECK cycle.
  localparam logic [7:0]       CNT_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [1:0]       idx;
  logic             x_q;
  logic             y_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_q;

  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic [3:0]       fail_next;

  // Result update for the vector currently being sampled (used only in CHECK).
  always_comb begin
    mismatch  = (bus.dut_z != EXPECT_MASK[idx]);
    err_next  = err_q;
    fail_next = fail_q;
    if (mismatch) begin
      fail_next[idx] = 1'b1;
      if (err_q != ERR_MAX) begin
        err_next = err_q + 1'b1;
      end
    end
  end

  // Sweep sequencer; every output comes straight from a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      x_q    <= 1'b0;
      y_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= SETTLE;
            idx    <= 2'd0;
            x_q    <= 1'b0;
            y_q    <= 1'b0;
            cnt    <= CNT_RELOAD;
            err_q  <= '0;
            fail_q <= '0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == 8'd0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CHECK: begin
          err_q  <= err_next;
          fail_q <= fail_next;
          if (idx == 2'd3) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == '0);
          end else begin
            state <= SETTLE;
            idx   <= idx + 2'd1;
            {x_q, y_q} <= idx + 2'd1;
            cnt   <= CNT_RELOAD;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_x     = x_q;
  assign bus.dut_y     = y_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_gate2_vector_checker.sv
// Bench for gate2_vector_checker: three checker instances (AND mask, OR mask,
// single-cycle settle) each facing a behavioural gate given as a 4-bit truth
// table. Outside the sample cycle the gate output is randomly glitched.
module tb_gate2_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] z_v;
  int         checks = 0;
  int         errors = 0;

  gate2_vector_checker_if #(.ERR_W(3)) bus0 ();
  gate2_vector_checker_if #(.ERR_W(3)) bus1 ();
  gate2_vector_checker_if #(.ERR_W(3)) bus2 ();

  gate2_vector_checker #(.EXPECT_MASK(4'b1000), .SETTLE_CYCLES(2), .ERR_W(3))
    u_and (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gate2_vector_checker #(.EXPECT_MASK(4'b1110), .SETTLE_CYCLES(2), .ERR_W(3))
    u_or (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gate2_vector_checker #(.EXPECT_MASK(4'b1000), .SETTLE_CYCLES(1), .ERR_W(3))
    u_fast (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [2:0] ox, oy, obusy, odone, opass;
  logic [2:0] oerr  [3];
  logic [3:0] ofail [3];

  assign bus0.start = start_v[0];
  assign bus1.start = start_v[1];
  assign bus2.start = start_v[2];
  assign bus0.dut_z = z_v[0];
  assign bus1.dut_z = z_v[1];
  assign bus2.dut_z = z_v[2];

  assign ox[0] = bus0.dut_x;  assign oy[0] = bus0.dut_y;
  assign ox[1] = bus1.dut_x;  assign oy[1] = bus1.dut_y;
  assign ox[2] = bus2.dut_x;  assign oy[2] = bus2.dut_y;
  assign obusy[0] = bus0.busy; assign odone[0] = bus0.done; assign opass[0] = bus0.pass;
  assign obusy[1] = bus1.busy; assign odone[1] = bus1.done; assign opass[1] = bus1.pass;
  assign obusy[2] = bus2.busy; assign odone[2] = bus2.done; assign opass[2] = bus2.pass;
  assign oerr[0] = bus0.err_count; assign ofail[0] = bus0.fail_vec;
  assign oerr[1] = bus1.err_count; assign ofail[1] = bus1.fail_vec;
  assign oerr[2] = bus2.err_count; assign ofail[2] = bus2.fail_vec;

  // Reference: mismatching vectors are those where the gate disagrees with the mask.
  function automatic logic [3:0] model_fail(input logic [3:0] tt, input logic [3:0] mask);
    return tt ^ mask;
  endfunction

  function automatic logic [2:0] model_err(input logic [3:0] tt, input logic [3:0] mask);
    int n = 0;
    logic [3:0] d = tt ^ mask;
    for (int i = 0; i < 4; i++) n += int'(d[i]);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

  function automatic logic [3:0] mask_of(input int inst);
    return (inst == 1) ? 4'b1110 : 4'b1000;
  endfunction

  function automatic int settle_of(input int inst);
    return (inst == 2) ? 1 : 2;
  endfunction

  // Runs one sweep starting at the current negedge. Vector k must be driven
  // on the s+1 cycles after edges k*(s+1)..k*(s+1)+s, and z is sampled at the
  // edge closing that window; cycles violating this timeline are counted in bad.
  task automatic do_sweep(input int inst, input logic [3:0] tt, input bit hold,
                          input bit repulse, output int bad, output logic o_done,
                          output logic o_busy, output logic o_pass,
                          output logic [2:0] o_err, output logic [3:0] o_fail,
                          output logic [1:0] o_vec);
    int s = settle_of(inst);
    int ev;
    bad = 0;
    start_v[inst] = 1'b1;
    z_v[inst] = 1'($urandom);
    for (int j = 0; j < 4 * (s + 1); j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j == 0 && !hold) start_v[inst] = 1'b0;
      if (repulse && j == 4) start_v[inst] = 1'b1;
      if (repulse && j == 5) start_v[inst] = 1'b0;
      ev = j / (s + 1);
      if ({ox[inst], oy[inst]} !== 2'(ev) || obusy[inst] !== 1'b1 || odone[inst] !== 1'b0)
        bad++;
      if (j == 0 && (oerr[inst] !== 3'd0 || ofail[inst] !== 4'd0 || opass[inst] !== 1'b0))
        bad++;
      z_v[inst] = (((j + 1) % (s + 1)) == 0) ? tt[ev] : 1'($urandom);
    end
    @(posedge clk);
    @(negedge clk);
    o_done = odone[inst];
    o_busy = obusy[inst];
    o_pass = opass[inst];
    o_err  = oerr[inst];
    o_fail = ofail[inst];
    o_vec  = {ox[inst], oy[inst]};
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_v = 3'b000;
    z_v     = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ox[i], oy[i], obusy[i], odone[i], opass[i], oerr[i], ofail[i]} !== 12'd0) begin
        errors++;
        $display("FAIL reset_values inst %0d: got x%b y%b busy%b done%b pass%b err%0d fail%b, want all 0",
                 i, ox[i], oy[i], obusy[i], odone[i], opass[i], oerr[i], ofail[i]);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obusy[i] !== 1'b0 || odone[i] !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_start inst %0d: got busy%b done%b, want 0 0", i, obusy[i], odone[i]);
      end
    end
  endtask

  task automatic test_fixed(input string name, input int inst, input logic [3:0] tt);
    int bad;
    logic d, b, p;
    logic [2:0] e;
    logic [3:0] f;
    logic [1:0] v;
    logic [3:0] exp_f = model_fail(tt, mask_of(inst));
    logic [2:0] exp_e = model_err(tt, mask_of(inst));
    do_sweep(inst, tt, 1'b0, 1'b0, bad, d, b, p, e, f, v);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_timeline: %0d off-timeline cycles, want 0", name, bad);
    end
    checks++;
    if (d !== 1'b1 || b !== 1'b0 || v !== 2'b11) begin
      errors++;
      $display("FAIL %s_done: got done%b busy%b vec%b, want 1 0 11", name, d, b, v);
    end
    checks++;
    if (e !== exp_e || f !== exp_f || p !== (exp_e == 3'd0)) begin
      errors++;
      $display("FAIL %s_result: got err%0d fail%b pass%b, want err%0d fail%b pass%b",
               name, e, f, p, exp_e, exp_f, (exp_e == 3'd0));
    end
  endtask

  task automatic test_gates();
    test_fixed("and_ok",   0, 4'b1000);
    test_fixed("stuck0",   0, 4'b0000);
    test_fixed("stuck1",   0, 4'b1111);
    test_fixed("or_vs_and", 0, 4'b1110);
    test_fixed("or_vs_or", 1, 4'b1110);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int inst = int'($urandom_range(0, 2));
      logic [3:0] tt = 4'($urandom);
      test_fixed("random", inst, tt);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    logic d, b, p;
    logic [2:0] e;
    logic [3:0] f;
    logic [1:0] v;
    do_sweep(0, 4'b0000, 1'b0, 1'b1, bad, d, b, p, e, f, v);
    checks++;
    if (bad !== 0 || d !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored_timing: bad %0d done%b, want 0 1", bad, d);
    end
    checks++;
    if (e !== 3'd1 || f !== 4'b1000 || p !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_result: got err%0d fail%b pass%b, want 1 1000 0", e, f, p);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (odone[0] !== 1'b1 || oerr[0] !== 3'd1 || ofail[0] !== 4'b1000 || obusy[0] !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: got done%b busy%b err%0d fail%b, want 1 0 1 1000",
               odone[0], obusy[0], oerr[0], ofail[0]);
    end
  endtask

  task automatic test_reset_midsweep();
    int bad;
    logic d, b, p;
    logic [2:0] e;
    logic [3:0] f;
    logic [1:0] v;
    start_v[0] = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      z_v[0] = 1'($urandom);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ox[0], oy[0], obusy[0], odone[0], opass[0], oerr[0], ofail[0]} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: got x%b y%b busy%b done%b err%0d fail%b, want all 0",
               ox[0], oy[0], obusy[0], odone[0], oerr[0], ofail[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obusy[0] !== 1'b0 || odone[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_aborts: got busy%b done%b, want 0 0", obusy[0], odone[0]);
    end
    do_sweep(0, 4'b1000, 1'b0, 1'b0, bad, d, b, p, e, f, v);
    checks++;
    if (bad !== 0 || d !== 1'b1 || p !== 1'b1 || e !== 3'd0 || f !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_sweep: bad %0d done%b pass%b err%0d fail%b, want 0 1 1 0 0000",
               bad, d, p, e, f);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic d, b, p;
    logic [2:0] e;
    logic [3:0] f;
    logic [1:0] v;
    for (int k = 0; k < 2; k++) begin
      do_sweep(2, 4'b0000, (k == 0), 1'b0, bad, d, b, p, e, f, v);
      checks++;
      if (bad !== 0 || d !== 1'b1 || b !== 1'b0) begin
        errors++;
        $display("FAIL b2b_timing sweep %0d: bad %0d done%b busy%b, want 0 1 0", k, bad, d, b);
      end
      checks++;
      if (e !== 3'd1 || f !== 4'b1000 || p !== 1'b0) begin
        errors++;
        $display("FAIL b2b_result sweep %0d: got err%0d fail%b pass%b, want 1 1000 0", k, e, f, p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_gates();
    test_random();
    test_start_ignored();
    test_reset_midsweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
